// File: rtl/sr1_mem_pkg.sv
// Shared definitions for the 16-bit CPU to 8-bit block-RAM bridge:
// FSM states, byte-lane indices and the legal read-latency range.
package sr1_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_WAIT = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  localparam int LANE_LO = 0;
  localparam int LANE_HI = 1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

endpackage

// File: rtl/bsram_word_bridge_if.sv
// CPU-side word request/response bus of the bridge.
interface bsram_word_bridge_if #(
  parameter int AW = 14
);
  logic          cpu_req;
  logic          cpu_we;
  logic [1:0]    cpu_be;
  logic [AW-1:0] cpu_addr;
  logic [15:0]   cpu_wdata;
  logic          cpu_busy;
  logic          cpu_ready;
  logic [15:0]   cpu_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    input  cpu_busy, cpu_ready, cpu_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    output cpu_busy, cpu_ready, cpu_rdata
  );
endinterface

// File: rtl/bsram_word_bridge_rd_lat_pipe.sv
// Read-latency tracker: carries {valid, hi_tag} for each read strobe so the
// returning byte is steered into the low or high half of the word.
module rd_lat_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_vld,
  input  logic in_hi,
  output logic out_vld,
  output logic out_hi
);

  logic [RD_LAT-1:0] vld_p;
  logic [RD_LAT-1:0] hi_p;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p <= '0;
      hi_p  <= '0;
    end else begin
      vld_p[0] <= in_vld;
      hi_p[0]  <= in_hi;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
        hi_p[i]  <= hi_p[i-1];
      end
    end
  end

  assign out_vld = vld_p[RD_LAT-1];
  assign out_hi  = hi_p[RD_LAT-1];

endmodule

// File: rtl/bsram_word_bridge.sv
// Bridges 16-bit word reads/writes onto an 8-bit byte-wide block RAM port,
// issuing the low byte then the high byte of each word.
module bsram_word_bridge
  import sr1_mem_pkg::*;
#(
  parameter int AW     = 14,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  bsram_word_bridge_if.slave    cpu,
  output logic                  mem_ce,
  output logic                  mem_oce,
  output logic                  mem_wre,
  output logic [AW:0]           mem_ad,
  output logic [7:0]            mem_din,
  input  logic [7:0]            mem_dout
);

  generate
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
      $error("bsram_word_bridge: RD_LAT must be within 1..2");
    end
  endgenerate

  state_t        state, state_nxt;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [1:0]    be_q;
  logic [15:0]   wdata_q;
  logic [7:0]    lo_q;
  logic [15:0]   rdata_q;
  logic          oce_q;

  logic          strobe_ce;
  logic          strobe_wre;
  logic [AW:0]   ad_c;
  logic [7:0]    din_c;
  logic          rd_vld;
  logic          rd_hi;
  logic          cap_vld;
  logic          cap_hi;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && cpu.cpu_req) begin
      addr_q  <= cpu.cpu_addr;
      we_q    <= cpu.cpu_we;
      be_q    <= cpu.cpu_be;
      wdata_q <= cpu.cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) oce_q <= 1'b0;
    else       oce_q <= 1'b1;
  end

  // Return stage: low byte parks in lo_q, the word publishes on the high byte.
  always_ff @(posedge clk) begin
    if (cap_vld && !cap_hi) lo_q <= mem_dout;
  end

  always_ff @(posedge clk) begin
    if (reset)                rdata_q <= '0;
    else if (cap_vld && cap_hi) rdata_q <= {mem_dout, lo_q};
  end

  rd_lat_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_lat_pipe (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (rd_vld),
    .in_hi   (rd_hi),
    .out_vld (cap_vld),
    .out_hi  (cap_hi)
  );

  always_comb begin
    state_nxt  = state;
    strobe_ce  = 1'b0;
    strobe_wre = 1'b0;
    ad_c       = '0;
    din_c      = '0;
    rd_vld     = 1'b0;
    rd_hi      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cpu.cpu_req) state_nxt = ST_LO;
      end
      ST_LO: begin
        ad_c  = {addr_q, 1'(LANE_LO)};
        din_c = wdata_q[8*LANE_LO +: 8];
        if (we_q) begin
          strobe_ce  = be_q[LANE_LO];
          strobe_wre = be_q[LANE_LO];
        end else begin
          strobe_ce = 1'b1;
          rd_vld    = 1'b1;
        end
        state_nxt = ST_HI;
      end
      ST_HI: begin
        ad_c  = {addr_q, 1'(LANE_HI)};
        din_c = wdata_q[8*LANE_HI +: 8];
        if (we_q) begin
          strobe_ce  = be_q[LANE_HI];
          strobe_wre = be_q[LANE_HI];
          state_nxt  = ST_RESP;
        end else begin
          strobe_ce = 1'b1;
          rd_vld    = 1'b1;
          rd_hi     = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cap_vld && cap_hi) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // The RAM samples its strobes on the same edge that applies reset, so they
  // are masked by reset to keep an interrupted access from touching memory.
  assign mem_ce  = strobe_ce  & ~reset;
  assign mem_wre = strobe_wre & ~reset;
  assign mem_ad  = ad_c;
  assign mem_din = din_c;
  assign mem_oce = oce_q;

  assign cpu.cpu_busy  = (state != ST_IDLE);
  assign cpu.cpu_ready = (state == ST_RESP);
  assign cpu.cpu_rdata = rdata_q;

endmodule

// File: tb/tb_bsram_word_bridge.sv
// Directed bench for bsram_word_bridge: two instances (RD_LAT 1 and 2), each
// on its own byte-RAM model, exercised with hand-computed word accesses.
module tb_bsram_word_bridge;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bsram_word_bridge_if #(.AW(14)) b1 ();
  bsram_word_bridge_if #(.AW(14)) b2 ();

  logic        ce1, oce1, wre1, ce2, oce2, wre2;
  logic [14:0] ad1, ad2;
  logic [7:0]  din1, din2, dout1, dout2, r2;

  bsram_word_bridge #(.AW(14), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .cpu(b1),
    .mem_ce(ce1), .mem_oce(oce1), .mem_wre(wre1),
    .mem_ad(ad1), .mem_din(din1), .mem_dout(dout1)
  );

  bsram_word_bridge #(.AW(14), .RD_LAT(2)) dut2 (
    .clk(clk), .reset(reset), .cpu(b2),
    .mem_ce(ce2), .mem_oce(oce2), .mem_wre(wre2),
    .mem_ad(ad2), .mem_din(din2), .mem_dout(dout2)
  );

  logic [7:0] mem1 [0:32767];
  logic [7:0] mem2 [0:32767];

  always @(posedge clk) begin
    if (ce1 && wre1)  mem1[ad1] <= din1;
    if (ce1 && !wre1) dout1 <= mem1[ad1];
  end

  always @(posedge clk) begin
    if (ce2 && wre2)  mem2[ad2] <= din2;
    if (ce2 && !wre2) r2 <= mem2[ad2];
    dout2 <= r2;
  end

  int n_checks = 0;
  int n_errors = 0;

  logic        lg_ce  [1:10];
  logic        lg_wre [1:10];
  logic        lg_rdy [1:10];
  logic        lg_bsy [1:10];
  logic [14:0] lg_ad  [1:10];
  logic [7:0]  lg_din [1:10];
  logic [15:0] lg_rd  [1:10];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_cpu(input bit sel, input logic req, input logic we, input logic [1:0] be,
                         input logic [13:0] addr, input logic [15:0] wdata);
    if (sel) begin
      b2.cpu_req = req; b2.cpu_we = we; b2.cpu_be = be; b2.cpu_addr = addr; b2.cpu_wdata = wdata;
    end else begin
      b1.cpu_req = req; b1.cpu_we = we; b1.cpu_be = be; b1.cpu_addr = addr; b1.cpu_wdata = wdata;
    end
  endtask

  task automatic sample(input bit sel, input int k);
    if (sel) begin
      lg_ce[k] = ce2; lg_wre[k] = wre2; lg_ad[k] = ad2; lg_din[k] = din2;
      lg_rdy[k] = b2.cpu_ready; lg_bsy[k] = b2.cpu_busy; lg_rd[k] = b2.cpu_rdata;
    end else begin
      lg_ce[k] = ce1; lg_wre[k] = wre1; lg_ad[k] = ad1; lg_din[k] = din1;
      lg_rdy[k] = b1.cpu_ready; lg_bsy[k] = b1.cpu_busy; lg_rd[k] = b1.cpu_rdata;
    end
  endtask

  // One word access; the request cycle is T and lg_*[k] holds cycle T+k.
  task automatic access(input bit sel, input logic we, input logic [1:0] be,
                        input logic [13:0] addr, input logic [15:0] wdata,
                        input bit hold_resp, output int rdy_at);
    rdy_at = 0;
    for (int k = 1; k <= 10; k++) sample(sel, k);
    @(negedge clk);
    set_cpu(sel, 1'b1, we, be, addr, wdata);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      sample(sel, k);
      if (lg_rdy[k]) begin
        rdy_at = k;
        if (!hold_resp) set_cpu(sel, 1'b0, 1'b0, 2'b00, 14'h0, 16'h0);
        break;
      end
    end
    if (rdy_at == 0) begin
      check_val("ready_timeout", 32'd0, 32'd1);
      set_cpu(sel, 1'b0, 1'b0, 2'b00, 14'h0, 16'h0);
    end
  endtask

  int  rdy;
  bit  saw_ready;

  initial begin
    reset = 1'b1;
    set_cpu(1'b0, 1'b0, 1'b0, 2'b00, 14'h0, 16'h0);
    set_cpu(1'b1, 1'b0, 1'b0, 2'b00, 14'h0, 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy",  b1.cpu_busy,  0);
    check_val("rst_ready", b1.cpu_ready, 0);
    check_val("rst_rdata", b1.cpu_rdata, 0);
    check_val("rst_ce",    ce1,  0);
    check_val("rst_wre",   wre1, 0);
    check_val("rst_ad",    ad1,  0);
    check_val("rst_din",   din1, 0);
    check_val("rst_oce",   oce1, 0);
    reset = 1'b0;
    @(negedge clk);
    check_val("oce_run", oce1, 1);

    // Full-word write 0xBEEF to word 0x0123
    access(1'b0, 1'b1, 2'b11, 14'h0123, 16'hBEEF, 1'b0, rdy);
    check_val("w_busy1", lg_bsy[1], 1);
    check_val("w_ce1",   lg_ce[1],  1);
    check_val("w_wre1",  lg_wre[1], 1);
    check_val("w_ad1",   lg_ad[1],  15'h0246);
    check_val("w_din1",  lg_din[1], 8'hEF);
    check_val("w_ce2",   lg_ce[2],  1);
    check_val("w_ad2",   lg_ad[2],  15'h0247);
    check_val("w_din2",  lg_din[2], 8'hBE);
    check_val("w_ce3",   lg_ce[3],  0);
    check_val("w_rdy",   rdy, 3);
    check_val("w_mem_lo", mem1[15'h0246], 8'hEF);
    check_val("w_mem_hi", mem1[15'h0247], 8'hBE);

    // Read it back with RD_LAT=1
    access(1'b0, 1'b0, 2'b00, 14'h0123, 16'h0, 1'b0, rdy);
    check_val("r_ce1",  lg_ce[1],  1);
    check_val("r_wre1", lg_wre[1], 0);
    check_val("r_ce2",  lg_ce[2],  1);
    check_val("r_ad2",  lg_ad[2],  15'h0247);
    check_val("r_ce3",  lg_ce[3],  0);
    check_val("r_rdy",  rdy, 4);
    check_val("r_data", lg_rd[4], 16'hBEEF);

    // High-byte-only write over 0xAAAA
    access(1'b0, 1'b1, 2'b11, 14'h0010, 16'hAAAA, 1'b0, rdy);
    access(1'b0, 1'b1, 2'b10, 14'h0010, 16'h1234, 1'b0, rdy);
    check_val("be10_ce1", lg_ce[1], 0);
    check_val("be10_ce2", lg_ce[2], 1);
    check_val("be10_ad2", lg_ad[2], 15'h0021);
    check_val("be10_din", lg_din[2], 8'h12);
    check_val("be10_rdy", rdy, 3);
    check_val("rdata_hold", b1.cpu_rdata, 16'hBEEF);
    access(1'b0, 1'b0, 2'b00, 14'h0010, 16'h0, 1'b0, rdy);
    check_val("be10_rb", lg_rd[4], 16'h12AA);

    // Empty byte-enable write: no strobes, still completes
    access(1'b0, 1'b1, 2'b00, 14'h0010, 16'hFFFF, 1'b0, rdy);
    check_val("be00_ce1", lg_ce[1], 0);
    check_val("be00_ce2", lg_ce[2], 0);
    check_val("be00_rdy", rdy, 3);
    access(1'b0, 1'b0, 2'b00, 14'h0010, 16'h0, 1'b0, rdy);
    check_val("be00_rb", lg_rd[4], 16'h12AA);

    // Top word of the address space, request left high through RESP
    access(1'b0, 1'b1, 2'b11, 14'h3FFF, 16'hCAFE, 1'b0, rdy);
    check_val("top_ad1", lg_ad[1], 15'h7FFE);
    check_val("top_ad2", lg_ad[2], 15'h7FFF);
    access(1'b0, 1'b0, 2'b00, 14'h3FFF, 16'h0, 1'b1, rdy);
    check_val("top_rb", lg_rd[4], 16'hCAFE);
    @(negedge clk);
    check_val("resp_req_busy1", b1.cpu_busy, 0);
    set_cpu(1'b0, 1'b0, 1'b0, 2'b00, 14'h0, 16'h0);
    @(negedge clk);
    check_val("resp_req_busy2", b1.cpu_busy, 0);
    check_val("resp_req_ce", ce1, 0);

    // Reset landing in the HI cycle of a write
    access(1'b0, 1'b1, 2'b11, 14'h0008, 16'h9999, 1'b0, rdy);
    @(negedge clk);
    set_cpu(1'b0, 1'b1, 1'b1, 2'b11, 14'h0008, 16'h5566);
    @(negedge clk);
    check_val("abort_lo_ce", ce1, 1);
    check_val("abort_lo_ad", ad1, 15'h0010);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("abort_hi_ce", ce1, 0);
    @(negedge clk);
    check_val("abort_busy",  b1.cpu_busy,  0);
    check_val("abort_ready", b1.cpu_ready, 0);
    check_val("abort_ce",    ce1,  0);
    check_val("abort_wre",   wre1, 0);
    check_val("abort_ad",    ad1,  0);
    check_val("abort_din",   din1, 0);
    check_val("abort_oce",   oce1, 0);
    check_val("abort_rdata", b1.cpu_rdata, 0);
    set_cpu(1'b0, 1'b0, 1'b0, 2'b00, 14'h0, 16'h0);
    reset = 1'b0;
    saw_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (b1.cpu_ready) saw_ready = 1'b1;
    end
    check_val("abort_no_ready", saw_ready, 0);
    check_val("abort_mem_lo", mem1[15'h0010], 8'h66);
    check_val("abort_mem_hi", mem1[15'h0011], 8'h99);
    access(1'b0, 1'b0, 2'b00, 14'h0008, 16'h0, 1'b0, rdy);
    check_val("abort_rb", lg_rd[4], 16'h9966);

    // RD_LAT=2 instance
    access(1'b1, 1'b1, 2'b11, 14'h0123, 16'hBEEF, 1'b0, rdy);
    check_val("l2_w_rdy", rdy, 3);
    access(1'b1, 1'b0, 2'b00, 14'h0123, 16'h0, 1'b0, rdy);
    check_val("l2_ce1",  lg_ce[1], 1);
    check_val("l2_ce2",  lg_ce[2], 1);
    check_val("l2_ce3",  lg_ce[3], 0);
    check_val("l2_rdy",  rdy, 5);
    check_val("l2_data", lg_rd[5], 16'hBEEF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bsram_word_bridge.md
BSRAM_WORD_BRIDGE -- requirements
Module: bsram_word_bridge

Interface
REQ-001 SHALL have parameter AW, default 14: CPU word-address width; memory byte address is AW+1 bits.
REQ-002 SHALL have parameter RD_LAT, default 1, legal 1..2: cycles from memory read strobe to valid mem_dout.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cpu_req  in  1  request strobe, sampled only in IDLE.
REQ-006 cpu_we  in  1  1 = write, 0 = read.
REQ-007 cpu_be  in  2  write byte enables: bit0 = low byte, bit1 = high byte; ignored on reads.
REQ-008 cpu_addr  in  AW  word address.
REQ-009 cpu_wdata  in  16  write data, little-endian.
REQ-010 cpu_busy  out  1  high whenever state != IDLE.
REQ-011 cpu_ready  out  1  one-cycle completion pulse.
REQ-012 cpu_rdata  out  16  read data, valid while cpu_ready=1 on reads.
REQ-013 mem_ce, mem_oce, mem_wre  out  1 each  byte-RAM port strobes.
REQ-014 mem_ad  out  AW+1  byte address; mem_din  out  8; mem_dout  in  8.

Function
REQ-015 FSM states SHALL be IDLE, LO, HI, WAIT, RESP.
REQ-016 IDLE with cpu_req=1 at cycle T SHALL latch addr/we/be/wdata and enter LO at T+1.
REQ-017 LO SHALL drive mem_ad={addr,1'b0} and mem_din=wdata[7:0]; HI SHALL drive mem_ad={addr,1'b1} and mem_din=wdata[15:8]; LO always goes to HI.
REQ-018 Reads SHALL assert mem_ce in LO and HI with mem_wre=0.
REQ-019 Writes SHALL assert mem_ce=mem_wre=1 in LO only if be[0]=1 and in HI only if be[1]=1; otherwise mem_ce=0 in that cycle.
REQ-020 mem_oce SHALL be 1 at all times outside reset.
REQ-021 Writes SHALL go HI->RESP, giving cpu_ready at T+3, including be=2'b00.
REQ-022 Reads SHALL go HI->WAIT; low byte SHALL be captured from mem_dout at the end of cycle T+1+RD_LAT and high byte at the end of T+2+RD_LAT; WAIT SHALL exit to RESP after the high-byte capture, giving cpu_ready at T+3+RD_LAT.
REQ-023 RESP SHALL last exactly one cycle with cpu_ready=1 and then return to IDLE; cpu_req in RESP SHALL be ignored.
REQ-024 cpu_rdata SHALL hold its last read value until the next read capture; writes SHALL NOT change it.
REQ-025 cpu_req while busy SHALL be ignored; the master holds cpu_req until cpu_ready.
REQ-026 mem_ad SHALL NOT wrap across words: addr={AW{1}} accesses bytes 2^(AW+1)-2 and 2^(AW+1)-1.
REQ-027 In IDLE, WAIT and RESP, mem_ce and mem_wre SHALL be 0.

Reset
REQ-028 reset=1 SHALL, at the next edge, force IDLE and clear cpu_ready, cpu_busy, cpu_rdata, mem_ce, mem_wre, mem_ad, mem_din, mem_oce and the latency pipe, regardless of state.
REQ-029 Reset during HI of a write SHALL leave the LO byte written and SHALL issue no further strobe.
REQ-030 A read aborted by reset SHALL produce no cpu_ready.

Structure
REQ-031 State enum, byte-lane index constants and the RD_LAT legal range SHALL reside in shared package sr1_mem_pkg.
REQ-032 One sub-module SHALL be used: rd_lat_pipe, an RD_LAT-deep shift register carrying {valid, hi_tag} per read strobe, whose outputs select the low or high capture.
REQ-033 Parameter checks SHALL reject RD_LAT outside 1..2 at elaboration.

Verification
REQ-034 Write addr=0x0123, wdata=0xBEEF, be=11 -> mem writes 0xEF@0x0246 in T+1 and 0xBE@0x0247 in T+2; cpu_ready at T+3.
REQ-035 Read addr=0x0123 after REQ-034, RD_LAT=1 -> mem_ce high in T+1 and T+2; cpu_ready at T+4 with cpu_rdata=0xBEEF; repeat with RD_LAT=2 -> ready at T+5.
REQ-036 Write be=10, wdata=0x1234 to addr=0x0010 over 0xAAAA -> only 0x0021 strobed; readback 0x12AA; be=00 -> no strobe, ready at T+3.
REQ-037 addr=0x3FFF write 0xCAFE then read -> bytes at 0x7FFE/0x7FFF, readback 0xCAFE; cpu_req pulsed during RESP -> no new transaction started.
REQ-038 Reset asserted in HI of a write of 0x5566 to addr=0x0008 -> byte 0x0010=0x66, byte 0x0011 unchanged, no cpu_ready, all outputs 0, busy=0 the next cycle.
